// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the byte-serial memory arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_REST  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Index of the final byte beat; size 2'b11 behaves as a word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            SIZE_B:  last_beat = 2'd0;
            SIZE_H:  last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - sign/zero extension of captured little-endian load bytes
module mem_load_ext
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic            is_signed,
    input  logic [XLEN-1:0] cap,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = cap;
        case (size)
            SIZE_B:  result = {{(XLEN-8){is_signed & cap[7]}}, cap[7:0]};
            SIZE_H:  result = {{(XLEN-16){is_signed & cap[15]}}, cap[15:0]};
            default: result = cap;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LS arbiter driving a byte-serial RAM port with programmable read latency
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              ls_done,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    arb_state_t        state, state_n;
    owner_t            owner, owner_n;
    logic [1:0]        size_q, size_n;
    logic              signed_q, signed_n;
    logic [XLEN-1:0]   wdata_q, wdata_n;
    logic [XLEN-1:0]   cap_q, cap_n, cap_next;
    logic [1:0]        beat_q, beat_n, beat_inc;
    logic [LAT_W-1:0]  lat_q, lat_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              mem_wr_n;
    logic [7:0]        mem_wdata_n;
    logic              if_done_n, ls_done_n;
    logic [XLEN-1:0]   if_rdata_n, ls_rdata_n;
    logic [XLEN-1:0]   ext_data;
    logic              at_last;

    // Capture buffer as it would look once this cycle's byte lands; feeds the extender.
    always_comb begin
        cap_next = cap_q;
        cap_next[{beat_q, 3'b000} +: 8] = mem_rdata;
    end

    mem_load_ext #(.XLEN(XLEN)) u_ext (
        .size      (size_q),
        .is_signed (signed_q),
        .cap       (cap_next),
        .result    (ext_data)
    );

    assign at_last  = (beat_q == last_beat(size_q));
    assign beat_inc = beat_q + 2'd1;

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        size_n      = size_q;
        signed_n    = signed_q;
        wdata_n     = wdata_q;
        cap_n       = cap_q;
        beat_n      = beat_q;
        lat_n       = lat_q;
        mem_addr_n  = mem_addr;
        mem_wr_n    = mem_wr;
        mem_wdata_n = mem_wdata;
        if_done_n   = 1'b0;
        ls_done_n   = 1'b0;
        if_rdata_n  = if_rdata;
        ls_rdata_n  = ls_rdata;

        case (state)
            ST_IDLE: begin
                if (ls_req) begin
                    owner_n    = OWN_LS;
                    size_n     = ls_size;
                    signed_n   = ls_signed;
                    wdata_n    = ls_wdata;
                    cap_n      = '0;
                    mem_addr_n = ls_addr;
                    beat_n     = 2'd0;
                    lat_n      = '0;
                    if (ls_we) begin
                        state_n     = ST_WRITE;
                        mem_wr_n    = 1'b1;
                        mem_wdata_n = ls_wdata[7:0];
                    end else begin
                        state_n = ST_READ;
                    end
                end else if (if_req && !if_cancel) begin
                    owner_n    = OWN_IF;
                    size_n     = SIZE_W;
                    signed_n   = 1'b0;
                    wdata_n    = '0;
                    cap_n      = '0;
                    mem_addr_n = if_addr;
                    beat_n     = 2'd0;
                    lat_n      = '0;
                    state_n    = ST_READ;
                end
            end

            ST_READ: begin
                // A flush beats even the final capture: the fetched word is stale.
                if (owner == OWN_IF && if_cancel) begin
                    state_n = ST_IDLE;
                end else if (lat_q != LAT_LAST) begin
                    lat_n = lat_q + LAT_W'(1);
                end else begin
                    lat_n = '0;
                    cap_n = cap_next;
                    if (at_last) begin
                        state_n = ST_REST;
                        if (owner == OWN_IF) begin
                            if_done_n  = 1'b1;
                            if_rdata_n = ext_data;
                        end else begin
                            ls_done_n  = 1'b1;
                            ls_rdata_n = ext_data;
                        end
                    end else begin
                        beat_n     = beat_inc;
                        mem_addr_n = mem_addr + ADDR_W'(1);
                    end
                end
            end

            ST_WRITE: begin
                if (at_last) begin
                    mem_wr_n  = 1'b0;
                    ls_done_n = 1'b1;
                    state_n   = ST_REST;
                end else begin
                    beat_n      = beat_inc;
                    mem_addr_n  = mem_addr + ADDR_W'(1);
                    mem_wdata_n = wdata_q[{beat_inc, 3'b000} +: 8];
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            size_q    <= SIZE_B;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            cap_q     <= '0;
            beat_q    <= 2'd0;
            lat_q     <= '0;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= 8'h00;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            size_q    <= size_n;
            signed_q  <= signed_n;
            wdata_q   <= wdata_n;
            cap_q     <= cap_n;
            beat_q    <= beat_n;
            lat_q     <= lat_n;
            mem_addr  <= mem_addr_n;
            mem_wr    <= mem_wr_n;
            mem_wdata <= mem_wdata_n;
            if_done   <= if_done_n;
            ls_done   <= ls_done_n;
            if_rdata  <= if_rdata_n;
            ls_rdata  <= ls_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at RD_LAT=2 and RD_LAT=1
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat = 2;
    logic sel = 1'b0;

    logic        if_req = 1'b0, if_cancel = 1'b0;
    logic        ls_req = 1'b0, ls_we = 1'b0, ls_signed = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;

    wire [1:0][31:0] d_if_rdata, d_ls_rdata, d_mem_addr;
    wire [1:0]       d_if_done, d_ls_done, d_mem_wr;
    wire [1:0][7:0]  d_mem_wdata, d_mem_rdata;

    logic [7:0] ram     [1024];
    logic [7:0] ref_mem [1024];

    typedef struct packed {logic is_if; logic chk_data; logic [31:0] data;} exp_t;
    typedef struct packed {logic [31:0] addr; logic [7:0] data;} wr_t;
    exp_t done_q[$];
    wr_t  wr_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : 1;
        localparam logic G_SEL = (g == 1);
        logic [31:0] addr_dly;
        always @(posedge clk) addr_dly <= d_mem_addr[g];
        assign d_mem_rdata[g] = ram[(LAT == 1) ? d_mem_addr[g][9:0] : addr_dly[9:0]];

        mem_arbiter #(.ADDR_W(32), .XLEN(32), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req && (sel == G_SEL)),
            .if_addr   (if_addr),
            .if_cancel (if_cancel && (sel == G_SEL)),
            .if_rdata  (d_if_rdata[g]),
            .if_done   (d_if_done[g]),
            .ls_req    (ls_req && (sel == G_SEL)),
            .ls_we     (ls_we),
            .ls_size   (ls_size),
            .ls_signed (ls_signed),
            .ls_addr   (ls_addr),
            .ls_wdata  (ls_wdata),
            .ls_rdata  (d_ls_rdata[g]),
            .ls_done   (d_ls_done[g]),
            .mem_wr    (d_mem_wr[g]),
            .mem_addr  (d_mem_addr[g]),
            .mem_wdata (d_mem_wdata[g]),
            .mem_rdata (d_mem_rdata[g])
        );
    end

    logic        cur_if_done, cur_ls_done, cur_mem_wr;
    logic [31:0] cur_if_rdata, cur_ls_rdata, cur_mem_addr;
    logic [7:0]  cur_mem_wdata;
    always_comb begin
        cur_if_done   = d_if_done[sel];
        cur_ls_done   = d_ls_done[sel];
        cur_mem_wr    = d_mem_wr[sel];
        cur_if_rdata  = d_if_rdata[sel];
        cur_ls_rdata  = d_ls_rdata[sel];
        cur_mem_addr  = d_mem_addr[sel];
        cur_mem_wdata = d_mem_wdata[sel];
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
        end else if (cur_mem_wr === 1'b1) begin
            ram[cur_mem_addr[9:0]] <= cur_mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (RD_LAT=%0d): got %h expected %h", name, lat, act, exp);
        end
    endtask

    // Monitor: every completion and every write beat is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (cur_if_done === 1'b1 || cur_ls_done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", {30'b0, cur_if_done, cur_ls_done}, 32'h0);
            end else begin
                e = done_q.pop_front();
                chk("done_owner", {30'b0, cur_if_done, cur_ls_done}, e.is_if ? 32'h2 : 32'h1);
                if (e.chk_data) chk(e.is_if ? "if_rdata" : "ls_rdata",
                                    e.is_if ? cur_if_rdata : cur_ls_rdata, e.data);
            end
        end
        if (cur_mem_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_wr_beat", 32'(wr_q.size()), 32'h1);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", cur_mem_addr, w.addr);
                chk("wr_data", {24'b0, cur_mem_wdata}, {24'b0, w.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic sgn);
        int n = nbytes(size);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[10'(addr + 32'(i))]) << (8 * i);
        if (n < 4 && sgn && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic do_if(input logic [31:0] addr);
        int n = 0;
        done_q.push_back('{1'b1, 1'b1, model_load(addr, 2'b10, 1'b0)});
        if_addr = addr;
        if_req  = 1'b1;
        do begin tick(); n++; end while (cur_if_done !== 1'b1 && n < 200);
        if_req = 1'b0;
        chk("if_latency", n, 1 + 4 * lat);
        tick();
    endtask

    task automatic do_ls(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        int nb = nbytes(size);
        int exp_lat;
        if (we) begin
            for (int i = 0; i < nb; i++) begin
                wr_q.push_back('{addr + 32'(i), wdata[8 * i +: 8]});
                ref_mem[10'(addr + 32'(i))] = wdata[8 * i +: 8];
            end
            done_q.push_back('{1'b0, 1'b0, 32'h0});
            exp_lat = nb + 1;
        end else begin
            done_q.push_back('{1'b0, 1'b1, model_load(addr, size, sgn)});
            exp_lat = 1 + nb * lat;
        end
        ls_we = we; ls_size = size; ls_signed = sgn; ls_addr = addr; ls_wdata = wdata;
        ls_req = 1'b1;
        do begin tick(); n++; end while (cur_ls_done !== 1'b1 && n < 200);
        ls_req = 1'b0;
        chk(we ? "st_latency" : "ld_latency", n, exp_lat);
        tick();
    endtask

    task automatic do_both(input logic [31:0] ia, input logic [31:0] la);
        int n = 0, ls_n = 0, if_n = 0;
        logic [1:0] got = 2'b00;
        done_q.push_back('{1'b0, 1'b1, model_load(la, 2'b10, 1'b0)});
        done_q.push_back('{1'b1, 1'b1, model_load(ia, 2'b10, 1'b0)});
        if_addr = ia; ls_addr = la; ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        while (got != 2'b11 && n < 300) begin
            tick(); n++;
            if (cur_ls_done === 1'b1) begin ls_req = 1'b0; got[0] = 1'b1; ls_n = n; end
            if (cur_if_done === 1'b1) begin if_req = 1'b0; got[1] = 1'b1; if_n = n; end
        end
        chk("both_done", {30'b0, got}, 32'h3);
        chk("both_ls_latency", ls_n, 1 + 4 * lat);
        chk("both_if_latency", if_n, 3 + 8 * lat);
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] a;
        int kind;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        ref_mem[10'h100] = 8'h11; ref_mem[10'h101] = 8'h22;
        ref_mem[10'h102] = 8'h33; ref_mem[10'h103] = 8'h44;
        ref_mem[10'h007] = 8'h80;
        repeat (3) tick();
        load = 1'b0;
        chk("rst_mem_wr", {30'b0, d_mem_wr}, 32'h0);
        chk("rst_done", {28'b0, d_if_done, d_ls_done}, 32'h0);
        chk("rst_mem_addr", d_mem_addr[0] | d_mem_addr[1], 32'h0);
        chk("rst_rdata", d_if_rdata[0] | d_ls_rdata[0] | d_if_rdata[1] | d_ls_rdata[1], 32'h0);
        rst = 1'b0;
        tick();

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            lat = (s == 0) ? 2 : 1;
            do_if(32'h100);
            do_ls(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
            do_ls(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
            do_ls(1'b1, 2'b01, 1'b0, 32'h201, 32'h0000_ABCD);
            do_ls(1'b0, 2'b01, 1'b1, 32'h201, 32'h0);
            do_both(32'h100, 32'h200);

            // Flush the fetch at every point of its read, including the final capture edge.
            for (int k = 1; k <= 4 * lat; k++) begin
                if_addr = 32'($urandom_range(32'h320, 32'h3F0));
                if_req = 1'b1;
                repeat (k) tick();
                if_req = 1'b0; if_cancel = 1'b1;
                a = 32'($urandom_range(32'h320, 32'h3F0));
                done_q.push_back('{1'b0, 1'b1, model_load(a, 2'b00, 1'b1)});
                ls_we = 1'b0; ls_size = 2'b00; ls_signed = 1'b1; ls_addr = a; ls_req = 1'b1;
                tick();
                if_cancel = 1'b0;
                n = 1;
                while (cur_ls_done !== 1'b1 && n < 200) begin tick(); n++; end
                ls_req = 1'b0;
                chk("cancel_ls_latency", n, 2 + lat);
                tick();
            end

            // Reset lands during the second beat of a word store.
            ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = $urandom;
            for (int i = 0; i < 2; i++) begin
                wr_q.push_back('{32'h300 + 32'(i), ls_wdata[8 * i +: 8]});
                ref_mem[10'h300 + 10'(i)] = ls_wdata[8 * i +: 8];
            end
            ls_req = 1'b1;
            tick(); tick();
            rst = 1'b1; ls_req = 1'b0;
            tick();
            chk("rst_mid_mem_wr", {31'b0, cur_mem_wr}, 32'h0);
            chk("rst_mid_ls_done", {31'b0, cur_ls_done}, 32'h0);
            rst = 1'b0;
            repeat (3) tick();
            do_ls(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);

            for (int r = 0; r < 25; r++) begin
                kind = $urandom_range(0, 2);
                a = ($urandom_range(0, 6) == 0) ? 32'hFFFF_FFFE
                                                 : 32'($urandom_range(32'h320, 32'h3F0));
                if (kind == 0) do_if(a);
                else do_ls(kind == 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           a, $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        repeat (4) tick();
        chk("done_q_drained", 32'(done_q.size()), 32'h0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
